// File: rtl/irq_timer_ctrl.sv
// Interrupt source for the CPU control unit: programmable down-counter timer plus
// edge-triggered external lines, each with a pending latch and mask, and a single in-service slot.
module irq_timer_ctrl #(
  parameter int                  DATA_W       = 8,
  parameter int                  N_EXT        = 4,
  parameter logic [2*DATA_W-1:0] RESET_PERIOD = 16'd999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_EXT-1:0]  ext_irq,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [DATA_W-1:0] cfg_wdata,
  output logic [DATA_W-1:0] cfg_rdata,
  input  logic              s_finish_interr,
  output logic              i_timer,
  output logic              s_interruption,
  output logic [2:0]        irq_id
);

  localparam int         CNT_W     = 2 * DATA_W;
  localparam logic [1:0] ADDR_PLO  = 2'd0;
  localparam logic [1:0] ADDR_PHI  = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_PEND = 2'd3;

  logic [CNT_W-1:0] period_reg, period_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             en_reg;
  logic [N_EXT-1:0] mask_reg;
  logic [N_EXT:0]   pend_reg, pend_next, pend_set, pend_clr;
  logic [N_EXT:0]   req_vec, take_onehot;
  logic [N_EXT-1:0] sync1_reg, sync2_reg, prev_reg;
  logic             in_service_reg;
  logic [2:0]       irq_id_reg, win_id;
  logic             tick, take;
  logic             wr_plo, wr_phi, wr_ctrl, wr_pend;
  logic             unused_wdata;

  assign unused_wdata = ^cfg_wdata[DATA_W-1:N_EXT+1];

  assign wr_plo  = cfg_we && (cfg_addr == ADDR_PLO);
  assign wr_phi  = cfg_we && (cfg_addr == ADDR_PHI);
  assign wr_ctrl = cfg_we && (cfg_addr == ADDR_CTRL);
  assign wr_pend = cfg_we && (cfg_addr == ADDR_PEND);

  assign tick    = en_reg && (count_reg == '0);
  assign req_vec = pend_reg & {mask_reg, en_reg};
  assign i_timer = (|req_vec) & ~in_service_reg;
  assign take    = i_timer;

  assign s_interruption = in_service_reg;
  assign irq_id         = irq_id_reg;

  // Rising edge seen after the synchronizer marks the line pending.
  assign pend_set[0] = tick;
  generate
    for (genvar gi = 0; gi < N_EXT; gi++) begin : g_ext_edge
      assign pend_set[gi+1] = sync2_reg[gi] & ~prev_reg[gi];
    end
  endgenerate

  // Lowest index wins, so the timer has top priority.
  always_comb begin
    win_id      = '0;
    take_onehot = '0;
    for (int i = N_EXT; i >= 0; i--) begin
      if (req_vec[i]) begin
        win_id         = 3'(i);
        take_onehot    = '0;
        take_onehot[i] = 1'b1;
      end
    end
  end

  // Sets are OR-ed in last so a simultaneous set beats either kind of clear.
  always_comb begin
    pend_clr = '0;
    if (take)
      pend_clr = pend_clr | take_onehot;
    if (wr_pend)
      pend_clr = pend_clr | cfg_wdata[N_EXT:0];
    pend_next = (pend_reg & ~pend_clr) | pend_set;
  end

  always_comb begin
    period_next = period_reg;
    if (wr_plo)
      period_next[DATA_W-1:0] = cfg_wdata;
    if (wr_phi)
      period_next[CNT_W-1:DATA_W] = cfg_wdata;
  end

  always_comb begin
    count_next = count_reg;
    if (wr_plo || wr_phi)
      count_next = period_next;
    else if (tick)
      count_next = period_reg;
    else if (en_reg)
      count_next = count_reg - 1'b1;
  end

  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      ADDR_PLO:  cfg_rdata = period_reg[DATA_W-1:0];
      ADDR_PHI:  cfg_rdata = period_reg[CNT_W-1:DATA_W];
      ADDR_CTRL: cfg_rdata[N_EXT:0] = {mask_reg, en_reg};
      default:   cfg_rdata[N_EXT:0] = pend_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      period_reg     <= RESET_PERIOD;
      count_reg      <= RESET_PERIOD;
      en_reg         <= 1'b0;
      mask_reg       <= '0;
      pend_reg       <= '0;
      sync1_reg      <= '0;
      sync2_reg      <= '0;
      prev_reg       <= '0;
      in_service_reg <= 1'b0;
      irq_id_reg     <= '0;
    end else begin
      period_reg <= period_next;
      count_reg  <= count_next;
      pend_reg   <= pend_next;
      sync1_reg  <= ext_irq;
      sync2_reg  <= sync1_reg;
      prev_reg   <= sync2_reg;
      if (wr_ctrl) begin
        en_reg   <= cfg_wdata[0];
        mask_reg <= cfg_wdata[N_EXT:1];
      end
      if (take) begin
        in_service_reg <= 1'b1;
        irq_id_reg     <= win_id;
      end else if (s_finish_interr) begin
        in_service_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_irq_timer_ctrl.sv
// Directed scenarios followed by randomized traffic, all checked cycle by cycle
// against a behavioural model of the interrupt controller.
module tb_irq_timer_ctrl;

  localparam int RP = 999;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ext_irq = '0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_wdata = '0;
  logic [7:0] cfg_rdata;
  logic       s_finish_interr = 1'b0;
  logic       i_timer;
  logic       s_interruption;
  logic [2:0] irq_id;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state: register contents, cycles left on the timer, and the last
  // three sampled values of the external lines (h1 newest).
  int m_period, m_count, m_en, m_mask, m_pend, m_busy, m_id;
  int h1, h2, h3;

  irq_timer_ctrl #(.DATA_W(8), .N_EXT(4), .RESET_PERIOD(16'd999)) dut (
    .clk            (clk),
    .reset          (reset),
    .ext_irq        (ext_irq),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .s_finish_interr(s_finish_interr),
    .i_timer        (i_timer),
    .s_interruption (s_interruption),
    .irq_id         (irq_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int exp_rd(input int a);
    case (a)
      0:       return m_period % 256;
      1:       return m_period / 256;
      2:       return m_mask * 2 + m_en;
      default: return m_pend;
    endcase
  endfunction

  function automatic int exp_req();
    int enabled;
    enabled = m_mask * 2 + m_en;
    return ((m_pend & enabled) != 0 && m_busy == 0) ? 1 : 0;
  endfunction

  // Advance the model by one clock using the inputs as currently driven,
  // then let the DUT take the same edge and compare.
  task automatic cyc();
    int set_b, req, clr, win, newp;
    bit tk;
    if (reset) begin
      m_period = RP; m_count = RP; m_en = 0; m_mask = 0; m_pend = 0;
      m_busy = 0; m_id = 0; h1 = 0; h2 = 0; h3 = 0;
    end else begin
      tk    = (m_en == 1) && (m_count == 0);
      set_b = ((h2 & ~h3) & 'hF) * 2 + (tk ? 1 : 0);
      req   = m_pend & (m_mask * 2 + m_en);
      clr   = 0;
      if (req != 0 && m_busy == 0) begin
        win = 0;
        while (((req >> win) & 1) == 0) win++;
        m_busy = 1;
        m_id   = win;
        clr    = 1 << win;
      end else if (s_finish_interr && m_busy == 1) begin
        m_busy = 0;
      end
      if (cfg_we && cfg_addr == 2'd3) clr = clr | int'(cfg_wdata);
      m_pend = ((m_pend & ~clr) | set_b) & 'h1F;
      if (cfg_we && cfg_addr < 2'd2) begin
        if (cfg_addr == 2'd0) newp = (m_period & 'hFF00) | int'(cfg_wdata);
        else                  newp = (m_period & 'h00FF) | (int'(cfg_wdata) << 8);
        m_period = newp;
        m_count  = newp;
      end else if (tk) begin
        m_count = m_period;
      end else if (m_en == 1) begin
        m_count = m_count - 1;
      end
      if (cfg_we && cfg_addr == 2'd2) begin
        m_en   = int'(cfg_wdata) & 1;
        m_mask = (int'(cfg_wdata) >> 1) & 'hF;
      end
      h3 = h2; h2 = h1; h1 = int'(ext_irq);
    end
    @(posedge clk);
    #1;
    chk("i_timer", i_timer, exp_req());
    chk("s_interruption", s_interruption, m_busy);
    chk("irq_id", irq_id, m_id);
    chk("cfg_rdata", cfg_rdata, exp_rd(int'(cfg_addr)));
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input int e);
    cfg_addr = a;
    #1;
    chk(tag, cfg_rdata, e);
  endtask

  task automatic finish_pulse();
    s_finish_interr = 1'b1;
    cyc();
    s_finish_interr = 1'b0;
  endtask

  initial begin
    int n;

    // Reset state
    cyc(); cyc();
    reset = 1'b0;
    chk("rst_i_timer", i_timer, 0);
    chk("rst_in_service", s_interruption, 0);
    chk("rst_irq_id", irq_id, 0);
    rd("rst_period_lo", 0, 'hE7);
    rd("rst_period_hi", 1, 'h03);
    rd("rst_ctrl", 2, 0);
    rd("rst_pend", 3, 0);

    // Period 3 gives a tick every 4 cycles
    wr(0, 8'd3); wr(1, 8'd0);
    rd("period_lo", 0, 3);
    rd("period_hi", 1, 0);
    wr(2, 8'h01);
    n = 0;
    while (!i_timer && n < 20) begin cyc(); n++; end
    chk("tick_latency", n, 4);
    rd("pend_tick", 3, 'h01);
    cyc();
    chk("take_timer_id", irq_id, 0);
    chk("take_timer_busy", s_interruption, 1);
    rd("pend_after_take", 3, 0);
    wr(2, 8'h04);

    // External edge while in service: latched, no request
    ext_irq[1] = 1'b1;
    cyc(); cyc();
    rd("ext_latency_early", 3, 0);
    cyc();
    rd("ext_pend2", 3, 'h04);
    chk("ext_in_service_no_req", i_timer, 0);
    finish_pulse();
    chk("fnsh_clears", s_interruption, 0);
    chk("fnsh_then_req", i_timer, 1);
    cyc();
    chk("take_ext1_id", irq_id, 2);
    chk("take_ext1_busy", s_interruption, 1);
    finish_pulse();
    ext_irq = '0;

    // Timer tick and ext_irq[0] edge on the same edge
    wr(2, 8'h03);
    wr(0, 8'd3);
    cyc();
    ext_irq[0] = 1'b1;
    cyc(); cyc(); cyc();
    rd("pend_both", 3, 'h03);
    cyc();
    chk("prio_timer_id", irq_id, 0);
    finish_pulse();
    chk("prio_fnsh", s_interruption, 0);
    cyc();
    chk("prio_ext0_id", irq_id, 1);
    chk("prio_ext0_busy", s_interruption, 1);
    wr(2, 8'h00);
    wr(3, 8'h1F);
    finish_pulse();
    ext_irq = '0;
    cyc(); cyc(); cyc();

    // Masked edge latches but does not request
    ext_irq[2] = 1'b1;
    cyc(); cyc(); cyc();
    rd("pend_masked", 3, 'h08);
    chk("masked_no_req", i_timer, 0);
    wr(2, 8'h08);
    chk("unmask_req", i_timer, 1);
    cyc();
    chk("take_ext2_id", irq_id, 3);

    // W1C against a simultaneous tick, then on a quiet cycle
    wr(2, 8'h09);
    wr(0, 8'd3);
    cyc(); cyc(); cyc();
    wr(3, 8'h01);
    rd("w1c_vs_tick", 3, 'h01);
    wr(3, 8'h01);
    rd("w1c_clear", 3, 'h00);

    // Reset in the middle of service with two lines pending
    wr(2, 8'h00);
    ext_irq[0] = 1'b1; ext_irq[1] = 1'b1;
    cyc(); cyc(); cyc();
    rd("pend_06", 3, 'h06);
    chk("busy_before_reset", s_interruption, 1);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("rst2_in_service", s_interruption, 0);
    chk("rst2_i_timer", i_timer, 0);
    chk("rst2_irq_id", irq_id, 0);
    rd("rst2_pend", 3, 0);
    rd("rst2_period_lo", 0, 'hE7);
    rd("rst2_period_hi", 1, 'h03);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 3) == 0) ext_irq = 4'($urandom);
      cfg_we   = ($urandom_range(0, 3) == 0);
      cfg_addr = 2'($urandom);
      case (cfg_addr)
        2'd0:    cfg_wdata = 8'($urandom_range(0, 6));
        2'd1:    cfg_wdata = ($urandom_range(0, 4) == 0) ? 8'd1 : 8'd0;
        default: cfg_wdata = 8'($urandom);
      endcase
      s_finish_interr = ($urandom_range(0, 5) == 0);
      cyc();
    end
    reset = 1'b0; cfg_we = 1'b0; s_finish_interr = 1'b0;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
